// File: rtl/seg7_scan_ctrl.sv
// Captures a 32-bit word from the bus and scans it as 8 hex digits onto a
// common-anode 7-segment display. Define SEG7_LZ_BLANK_EN for leading-zero blanking.
module seg7_scan_ctrl #(
  parameter int SCAN_DIV = 100000,
  parameter int DIV_W    = 17
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        seg7_we,
  input  logic [31:0] cpuseg7_data,
  input  logic [7:0]  dp_i,
  input  logic        disp_en,
  output logic [7:0]  disp_an,
  output logic [7:0]  disp_seg,
  output logic [31:0] disp_data
);

  logic [31:0]      data_q, data_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       an_q, an_d;
  logic [7:0]       seg_q, seg_d;
  logic [4:0]       nib_lsb;
  logic [3:0]       nib;
  logic             blank;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  always_comb begin
    data_d = seg7_we ? cpuseg7_data : data_q;
    div_d  = div_q + DIV_W'(1);
    idx_d  = idx_q;
    if (div_q == DIV_W'(SCAN_DIV - 1)) begin
      div_d = '0;
      idx_d = idx_q + 3'd1;
    end
  end

  assign nib_lsb = {idx_q, 2'b00};
  assign nib     = data_q[nib_lsb +: 4];

`ifdef SEG7_LZ_BLANK_EN
  // A digit is a leading zero when everything from it upward is zero.
  always_comb begin
    blank = 1'b0;
    if (idx_q != 3'd0) blank = ((data_q >> nib_lsb) == 32'd0);
  end
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    an_d  = (disp_en && !blank) ? ~(8'b1 << idx_q) : 8'hFF;
    seg_d = blank ? 8'hFF : {~dp_i[idx_q], hex7(nib)};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_q <= '0;
      div_q  <= '0;
      idx_q  <= '0;
      an_q   <= 8'hFF;
      seg_q  <= 8'hFF;
    end else begin
      data_q <= data_d;
      div_q  <= div_d;
      idx_q  <= idx_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
    end
  end

  assign disp_an   = an_q;
  assign disp_seg  = seg_q;
  assign disp_data = data_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed self-checking bench for seg7_scan_ctrl with a short scan slot (SCAN_DIV=4).
module tb_seg7_scan_ctrl;

  localparam int SD = 4;
`ifdef SEG7_LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  localparam logic [7:0] SCAN_SEG [8] = '{8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80};
  localparam logic [7:0] A05_SEG  [8] = '{8'h92, 8'hC0, 8'h88, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};

  logic        clk = 1'b0;
  logic        rstn;
  logic        seg7_we;
  logic [31:0] cpuseg7_data;
  logic [7:0]  dp_i;
  logic        disp_en;
  logic [7:0]  disp_an;
  logic [7:0]  disp_seg;
  logic [31:0] disp_data;

  int checks = 0;
  int errors = 0;
  int k = 0;

  seg7_scan_ctrl #(.SCAN_DIV(SD), .DIV_W(3)) dut (
    .clk(clk), .rstn(rstn), .seg7_we(seg7_we), .cpuseg7_data(cpuseg7_data),
    .dp_i(dp_i), .disp_en(disp_en), .disp_an(disp_an), .disp_seg(disp_seg),
    .disp_data(disp_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s k=%0d got %h expected %h", tag, k, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    k++;
  endtask

  // Digit whose slot is shown after edge k (outputs lag the index by one edge).
  function automatic int dig(input int kk);
    return ((kk - 1) / SD) % 8;
  endfunction

  function automatic bit lz(input int d, input logic [31:0] w);
    return LZ && (d != 0) && ((w >> (4 * d)) == 32'd0);
  endfunction

  task automatic chk_slot(input string tag, input logic [31:0] w, input logic [7:0] raw, input bit en);
    int d;
    d = dig(k);
    chk({tag, "_an"}, {24'd0, disp_an},
        (lz(d, w) || !en) ? 32'hFF : {24'd0, ~(8'b1 << d)});
    chk({tag, "_seg"}, {24'd0, disp_seg}, lz(d, w) ? 32'hFF : {24'd0, raw});
  endtask

  initial begin
    rstn = 1'b0; seg7_we = 1'b0; cpuseg7_data = '0; dp_i = '0; disp_en = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_an", {24'd0, disp_an}, 32'hFF);
      chk("rst_seg", {24'd0, disp_seg}, 32'hFF);
      chk("rst_data", disp_data, 32'h0);
    end
    rstn = 1'b1;
    k = 0;
    step();
    chk("first_an", {24'd0, disp_an}, 32'hFE);
    chk("first_seg", {24'd0, disp_seg}, 32'hC0);

    // full scan of 89ABCDEF, including the wrap back to digit 0
    seg7_we = 1'b1; cpuseg7_data = 32'h89AB_CDEF;
    step();
    seg7_we = 1'b0;
    chk("cap_data", disp_data, 32'h89AB_CDEF);
    while (k < 37) begin
      step();
      chk_slot("scan", 32'h89AB_CDEF, SCAN_SEG[dig(k)], 1'b1);
    end

    // display off for 6 cycles; scan keeps running
    disp_en = 1'b0;
    repeat (6) begin
      step();
      chk_slot("dis", 32'h89AB_CDEF, SCAN_SEG[dig(k)], 1'b0);
    end
    disp_en = 1'b1;
    step();
    chk_slot("reen", 32'h89AB_CDEF, SCAN_SEG[dig(k)], 1'b1);

    // decimal point on digit 2 only
    dp_i = 8'h04; seg7_we = 1'b1; cpuseg7_data = 32'h0;
    step();
    seg7_we = 1'b0;
    repeat (32) begin
      step();
      chk_slot("dp", 32'h0, (dig(k) == 2) ? 8'h40 : 8'hC0, 1'b1);
    end

    // write in the second cycle of the digit-0 slot
    dp_i = 8'h00;
    while ((k % (8 * SD)) != 0) step();
    step();
    chk("wr_seg0", {24'd0, disp_seg}, 32'hC0);
    seg7_we = 1'b1; cpuseg7_data = 32'h5;
    step();
    seg7_we = 1'b0;
    chk("wr_seg1", {24'd0, disp_seg}, 32'hC0);
    step();
    chk("wr_seg2", {24'd0, disp_seg}, 32'h92);
    chk("wr_an", {24'd0, disp_an}, 32'hFE);
    chk("wr_data", disp_data, 32'h5);

    // leading-zero behaviour depends on the build
    seg7_we = 1'b1; cpuseg7_data = 32'h0000_0A05;
    step();
    seg7_we = 1'b0;
    repeat (32) begin
      step();
      chk_slot("lz", 32'h0000_0A05, A05_SEG[dig(k)], 1'b1);
    end

    // back-to-back strobes: last one wins
    seg7_we = 1'b1; cpuseg7_data = 32'h1111_1111;
    step();
    chk("b2b_first", disp_data, 32'h1111_1111);
    cpuseg7_data = 32'h2222_2222;
    step();
    seg7_we = 1'b0; cpuseg7_data = 32'h3333_3333;
    step();
    chk("b2b_last", disp_data, 32'h2222_2222);

    // reset mid-scan
    step();
    rstn = 1'b0;
    #1;
    chk("mrst_an", {24'd0, disp_an}, 32'hFF);
    chk("mrst_seg", {24'd0, disp_seg}, 32'hFF);
    chk("mrst_data", disp_data, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    k = 0;
    step();
    chk("mrst_an1", {24'd0, disp_an}, 32'hFE);
    chk("mrst_seg1", {24'd0, disp_seg}, 32'hC0);
    repeat (4) step();
    chk("mrst_an5", {24'd0, disp_an}, 32'hFD);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- Downstream consumer of the memory-IO bus seg7 write path.
- Captures the 32-bit word the CPU stores to the seg7 address when the bus write strobe is asserted.
- Time-multiplexes the word as 8 hex digits onto the board's common-anode 8-digit 7-segment display.
- Sits in the FPGA top between the bus decoder and the display pins.

Parameters:
- SCAN_DIV, 100000: clk cycles per digit slot; must be >= 2.
- DIV_W, 17: divider counter width; must satisfy 2^DIV_W >= SCAN_DIV.

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- seg7_we  input  1  capture strobe from bus decoder.
- cpuseg7_data  input  32  data word from bus decoder.
- dp_i  input  8  decimal-point enable per digit; bit i = digit i; 1 = lit.
- disp_en  input  1  1 = display on; 0 = all anodes off, scanning continues.
- disp_an  output  8  digit anodes, active-low; bit i = digit i.
- disp_seg  output  8  segments {dp,g,f,e,d,c,b,a}, active-low.
- disp_data  output  32  currently latched word, for debug/readback.

Behaviour:
- Reset (rstn=0, asynchronous):
  - data_reg = 0, div_cnt = 0, idx = 0.
  - disp_an = 8'hFF, disp_seg = 8'hFF, disp_data = 0.
- Capture:
  - seg7_we=1 at a clk edge loads data_reg <= cpuseg7_data. Otherwise data_reg holds.
  - disp_data = data_reg, driven combinationally from the register.
  - Back-to-back strobes: the last strobe wins.
- Divider:
  - div_cnt increments each cycle.
  - When div_cnt == SCAN_DIV-1: div_cnt <= 0 and idx <= idx+1 (3-bit, 7 wraps to 0).
  - Each digit slot is exactly SCAN_DIV cycles; a full frame is 8*SCAN_DIV cycles.
- Output register (updated every clk):
  - nib = data_reg[4*idx+3 : 4*idx].
  - disp_an <= disp_en ? ~(8'b1 << idx) : 8'hFF.
  - disp_seg <= {~dp_i[idx], hex7(nib)}.
- Latency:
  - Outputs reflect idx/data_reg state one cycle later.
  - A write at edge N shows on disp_seg at edge N+1 if its digit is being scanned.
- hex7 table (gfedcba, active-low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Simultaneous events:
  - A capture and a digit advance in the same cycle both take effect.
  - The next output uses the new idx and the new data.
- Reset mid-scan: all state returns to reset values immediately; scan restarts at digit 0.
- disp_en toggling does not disturb div_cnt or idx.

Optional Feature:
- Macro: SEG7_LZ_BLANK_EN (leading-zero blanking).
- Defined:
  - Digit i (i >= 1) is blanked when data_reg[31:4*i] == 0 (disp_an bit i = 1, disp_seg = 8'hFF for that slot).
  - Digit 0 is never blanked.
  - The blank decision uses the same data_reg value as the segment decode.
  - Slot timing is unchanged.
- Undefined: all 8 digits are always shown, including leading zeros.

Test Plan:
- Reset (SCAN_DIV=4): hold rstn=0 for 3 cycles, release -> disp_an=FF, disp_seg=FF during reset; first edge after release gives disp_an=FE, disp_seg=C0 (digit 0 = "0", dp off).
- Capture and scan: pulse seg7_we with cpuseg7_data=32'h89ABCDEF, disp_en=1, dp_i=0; observe 32 cycles -> anodes FE,FD,FB,F7,EF,DF,BF,7F, each held 4 cycles; segments 8E,86,A1,C6,83,88,90,80; wraps to FE.
- Decimal point: dp_i=8'h04 with data 32'h00000000 -> digit 2 slot shows disp_seg=40, all other slots C0.
- disp_en=0 mid-frame for 6 cycles -> disp_an=FF from the next edge; on re-enable the scan index has advanced as if never disabled.
- Write during the digit-0 slot: data 0 -> 32'h00000005 with seg7_we at cycle 1 of the slot -> disp_seg changes C0 -> 92 one edge later; disp_data=5.
- SEG7_LZ_BLANK_EN defined, data 32'h00000A05 -> digits 3..7 blanked (anode high, seg FF); digits 0..2 show 92, C0, 88. With the macro undefined -> all digits shown.
